// File: rtl/gf180mcu_fd_sc_mcu9t5v0__norn_filt.sv
// Masked N-input NOR, registered, with a consecutive-cycle glitch filter, edge pulses and optional sticky flag.
// Optional sticky flag and its CLR input are built only when GF180MCU_FD_SC_MCU9T5V0_NORN_STICKY_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__norn_filt #(
  parameter int WIDTH = 4,
  parameter int FILT  = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] MASK,
  input  logic             CLR,
  output logic             ZN_RAW,
  output logic             ZN,
  output logic             RISE,
  output logic             FALL,
  output logic             STICKY
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic          raw;
  logic          zn_raw_q, zn_raw_d;
  logic          zn_q, zn_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign raw = ~|(A & ~MASK);

  // The filter compares the registered sample, so ZN lags ZN_RAW by exactly FILT edges.
  always_comb begin
    zn_raw_d = zn_raw_q;
    zn_d     = zn_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (EN) begin
      zn_raw_d = raw;
      if (zn_raw_q != zn_q) begin
        if (cnt_q == CNT_LAST) begin
          zn_d   = zn_raw_q;
          cnt_d  = '0;
          rise_d = zn_raw_q;
          fall_d = ~zn_raw_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      zn_raw_q <= 1'b0;
      zn_q     <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      zn_raw_q <= zn_raw_d;
      zn_q     <= zn_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign ZN_RAW = zn_raw_q;
  assign ZN     = zn_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_STICKY_EN
  logic sticky_q, sticky_d;

  // A rise being registered this edge beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (rise_d)
      sticky_d = 1'b1;
    else if (EN && CLR)
      sticky_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RN)
      sticky_q <= 1'b0;
    else
      sticky_q <= sticky_d;
  end

  assign STICKY = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = CLR;
  assign STICKY     = 1'b0;
`endif

endmodule
